fib_bcd_gen: RTL and testbench

Sequential Fibonacci sequence generator. It produces F0, F1, F2, ... as packed BCD words and hands them out over a valid/ready stream. It is the producing end for the team's Fibonacci-recognizer path: each emitted word can be fed digit-by-digit into the recognizer. The sum is computed digit-serially with a single BCD digit adder, and the sequence stops on a requested term count or on BCD overflow.

---
 rtl/fib_bcd_gen.sv | 129 ++++++++++++
 tb/tb_fib_bcd_gen.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_bcd_gen.sv
// Fibonacci term generator producing packed-BCD words over a valid/ready stream.
// Each new term is summed one BCD digit per cycle through a single digit adder.
module fib_bcd_gen #(
    parameter int DIGITS = 4,
    parameter int IDX_W  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [IDX_W-1:0]      n_terms,
    output logic [4*DIGITS-1:0]   term_bcd,
    output logic [IDX_W-1:0]      term_idx,
    output logic                  valid,
    input  logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int DP_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DP_W-1:0] LAST_DIGIT = DP_W'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, EMIT, ADD, DONE} state_t;

    state_t                 state;
    logic [DIGITS-1:0][3:0] prev;
    logic [DIGITS-1:0][3:0] cur;
    logic [DIGITS-1:0][3:0] nxt;
    logic [DIGITS-1:0][3:0] sum_word;
    logic [IDX_W-1:0]       n_lat;
    logic [IDX_W-1:0]       k;
    logic [IDX_W:0]         k_inc;
    logic [DP_W-1:0]        dptr;
    logic                   carry;
    logic [4:0]             digit_sum;
    logic [3:0]             digit_out;
    logic                   digit_carry;

    // One BCD digit add; sum_word is the accumulator with the current digit merged in,
    // so the final digit can be committed to cur in the same cycle it is computed.
    always_comb begin
        digit_sum   = {1'b0, prev[dptr]} + {1'b0, cur[dptr]} + {4'd0, carry};
        digit_carry = (digit_sum > 5'd9);
        digit_out   = digit_carry ? (digit_sum[3:0] + 4'd6) : digit_sum[3:0];
        sum_word       = nxt;
        sum_word[dptr] = digit_out;
        k_inc = {1'b0, k} + 1'b1;
    end

    assign term_bcd = cur;
    assign term_idx = k;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            prev     <= '0;
            cur      <= '0;
            nxt      <= '0;
            n_lat    <= '0;
            k        <= '0;
            dptr     <= '0;
            carry    <= 1'b0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        n_lat    <= n_terms;
                        prev     <= (4*DIGITS)'(1);
                        cur      <= '0;
                        k        <= '0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        if (n_terms == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= EMIT;
                            valid <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (ready) begin
                        k     <= k_inc[IDX_W-1:0];
                        valid <= 1'b0;
                        if (k_inc == {1'b0, n_lat}) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ADD;
                            dptr  <= '0;
                            carry <= 1'b0;
                        end
                    end
                end
                ADD: begin
                    nxt   <= sum_word;
                    carry <= digit_carry;
                    dptr  <= dptr + 1'b1;
                    // A carry out of the top digit means the term is unrepresentable.
                    if (dptr == LAST_DIGIT) begin
                        if (digit_carry) begin
                            overflow <= 1'b1;
                            state    <= DONE;
                            done     <= 1'b1;
                        end else begin
                            prev  <= cur;
                            cur   <= sum_word;
                            state <= EMIT;
                            valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fib_bcd_gen.sv
// Self-checking bench for fib_bcd_gen: table-driven runs, a mid-ADD reset sequence
// and randomized runs, all checked against an integer Fibonacci reference model.
module tb_fib_bcd_gen;

    localparam int DIGITS = 4;
    localparam int IDX_W  = 5;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [IDX_W-1:0]   n_terms;
    logic [4*DIGITS-1:0] term_bcd;
    logic [IDX_W-1:0]   term_idx;
    logic               valid;
    logic               ready;
    logic               busy;
    logic               done;
    logic               overflow;

    int checks   = 0;
    int failures = 0;

    logic [4*DIGITS-1:0] exp_terms[$];

    typedef struct {
        int                  n;
        int                  ready_pct;
        bit                  chk_gap;
        int                  stall_idx;
        bit                  busy_start;
        int                  exp_count;
        logic [4*DIGITS-1:0] exp_last;
        bit                  exp_ovf;
    } vec_t;

    vec_t vecs[7];

    fib_bcd_gen #(.DIGITS(DIGITS), .IDX_W(IDX_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .n_terms  (n_terms),
        .term_bcd (term_bcd),
        .term_idx (term_idx),
        .valid    (valid),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    function automatic logic [4*DIGITS-1:0] to_bcd(input longint v);
        logic [4*DIGITS-1:0] r;
        longint x;
        r = '0;
        x = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Reference: plain integer Fibonacci, stopping at the first term that needs more digits.
    task automatic buildModel(input int n, output bit ovf);
        longint a, b, t, limit;
        a = 0;
        b = 1;
        limit = 1;
        ovf = 0;
        for (int d = 0; d < DIGITS; d++) limit = limit * 10;
        exp_terms.delete();
        for (int i = 0; i < n; i++) begin
            if (a >= limit) begin
                ovf = 1;
                break;
            end
            exp_terms.push_back(to_bcd(a));
            t = a + b;
            a = b;
            b = t;
        end
    endtask

    task automatic applyStimulus(input int n, input int ready_pct, input bit chk_gap,
                                 input int stall_idx, input bit busy_start,
                                 output int got_count, output logic [4*DIGITS-1:0] got_last,
                                 output logic got_ovf);
        bit                  exp_ovf;
        bit                  finished;
        bit                  bad;
        int                  last_hs;
        int                  stall_left;
        logic                last_valid;
        logic                last_ready;
        logic [4*DIGITS-1:0] last_term;
        logic [IDX_W-1:0]    last_idx;

        buildModel(n, exp_ovf);
        got_count  = 0;
        got_last   = '0;
        got_ovf    = 1'b0;
        finished   = 0;
        last_hs    = -1;
        stall_left = 3;
        last_valid = 1'b0;
        last_ready = 1'b0;
        last_term  = '0;
        last_idx   = '0;

        @(negedge clk);
        start   = 1'b1;
        n_terms = IDX_W'(n);
        for (int cyc = 1; cyc <= 1500 && !finished; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start = 1'b0;
                checkOutput("ovf_cleared_on_start", overflow, 0);
                checkOutput("first_cycle_response", (n == 0) ? done : valid, 1);
            end
            if (busy_start) begin
                if (cyc == 2) begin
                    checkOutput("busy_during_stream", busy, 1);
                    start   = 1'b1;
                    n_terms = IDX_W'(9);
                end else if (cyc == 3) begin
                    start = 1'b0;
                end
            end
            ready = ($urandom_range(99) < ready_pct);
            if (valid && stall_left > 0 && int'(term_idx) == stall_idx) begin
                ready = 1'b0;
                stall_left--;
            end
            if (last_valid && !last_ready) begin
                checkOutput("stall_valid", valid, 1);
                checkOutput("stall_term", term_bcd, last_term);
                checkOutput("stall_idx", term_idx, last_idx);
            end
            if (valid) begin
                bad = 0;
                for (int d = 0; d < DIGITS; d++)
                    if (term_bcd[4*d +: 4] > 4'd9) bad = 1;
                checkOutput("bcd_digit_range", bad, 0);
            end
            if (valid && ready) begin
                if (got_count < exp_terms.size())
                    checkOutput("term", term_bcd, exp_terms[got_count]);
                else
                    checkOutput("extra_term", 1, 0);
                checkOutput("idx", term_idx, got_count);
                if (got_count == 17) checkOutput("idx17_carry", term_bcd, 16'h1597);
                if (chk_gap && last_hs >= 0) checkOutput("valid_gap", cyc - last_hs, DIGITS + 1);
                last_hs  = cyc;
                got_last = term_bcd;
                got_count++;
            end
            if (done) begin
                checkOutput("done_valid_low", valid, 0);
                checkOutput("done_busy_high", busy, 1);
                checkOutput("overflow", overflow, exp_ovf);
                checkOutput("count_vs_model", got_count, exp_terms.size());
                got_ovf  = overflow;
                finished = 1;
            end
            last_valid = valid;
            last_ready = ready;
            last_term  = term_bcd;
            last_idx   = term_idx;
        end
        if (!finished) begin
            checkOutput("timeout_waiting_done", 0, 1);
        end else begin
            @(negedge clk);
            checkOutput("done_single_pulse", done, 0);
            checkOutput("idle_not_busy", busy, 0);
        end
        ready = 1'b0;
    endtask

    initial begin
        int                  got_count;
        logic [4*DIGITS-1:0] got_last;
        logic                got_ovf;
        bit                  found;

        vecs[0] = '{7,  100, 1, -1, 0, 7,  16'h0008, 0};
        vecs[1] = '{31, 100, 1, -1, 0, 21, 16'h6765, 1};
        vecs[2] = '{4,  100, 1, -1, 1, 4,  16'h0002, 0};
        vecs[3] = '{12, 100, 0,  7, 0, 12, 16'h0089, 0};
        vecs[4] = '{0,  100, 0, -1, 0, 0,  16'h0000, 0};
        vecs[5] = '{20, 60,  0, -1, 0, 20, 16'h4181, 0};
        vecs[6] = '{25, 50,  0, -1, 0, 21, 16'h6765, 1};

        reset   = 1'b1;
        start   = 1'b0;
        ready   = 1'b0;
        n_terms = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_term", term_bcd, 0);
        checkOutput("reset_idx", term_idx, 0);
        checkOutput("reset_valid", valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_overflow", overflow, 0);
        reset = 1'b0;

        for (int v = 0; v < 7; v++) begin
            applyStimulus(vecs[v].n, vecs[v].ready_pct, vecs[v].chk_gap, vecs[v].stall_idx,
                          vecs[v].busy_start, got_count, got_last, got_ovf);
            checkOutput("table_count", got_count, vecs[v].exp_count);
            if (vecs[v].exp_count > 0) checkOutput("table_last_term", got_last, vecs[v].exp_last);
            checkOutput("table_overflow", got_ovf, vecs[v].exp_ovf);
        end

        // Reset while the adder is mid-term must clear everything without a done pulse.
        @(negedge clk);
        start   = 1'b1;
        n_terms = IDX_W'(10);
        ready   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (valid && term_idx == 5) found = 1;
            else @(negedge clk);
        end
        checkOutput("reached_idx5", found, 1);
        @(posedge clk);
        #7;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_term", term_bcd, 0);
        checkOutput("async_reset_idx", term_idx, 0);
        checkOutput("async_reset_valid", valid, 0);
        checkOutput("async_reset_busy", busy, 0);
        checkOutput("async_reset_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        ready = 1'b0;
        @(negedge clk);
        checkOutput("no_done_after_reset", done, 0);
        applyStimulus(3, 100, 1, -1, 0, got_count, got_last, got_ovf);
        checkOutput("post_reset_count", got_count, 3);
        checkOutput("post_reset_last", got_last, 16'h0001);

        for (int r = 0; r < 8; r++) begin
            applyStimulus(int'($urandom_range(31)), int'($urandom_range(100, 25)), 0, -1, 0,
                          got_count, got_last, got_ovf);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
